// File: rtl/bcd_clock_pkg.sv
// rtl/bcd_clock_pkg.sv - shared types and 2-digit BCD step helpers for the clock core
package bcd_clock_pkg;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  // Step a 2-digit BCD value up; bit 8 is the carry raised when wrapping from max to 00
  function automatic logic [8:0] bcd2_inc(input logic [7:0] val, input logic [7:0] max);
    logic [8:0] res;
    if (val == max) begin
      res = {1'b1, BCD_ZERO};
    end else if (val[3:0] == 4'h9) begin
      res = {1'b0, val[7:4] + 4'h1, 4'h0};
    end else begin
      res = {1'b0, val[7:4], val[3:0] + 4'h1};
    end
    return res;
  endfunction

  // Step a 2-digit BCD value down; 00 wraps to max and no borrow leaves the field
  function automatic logic [7:0] bcd2_dec(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val == BCD_ZERO) begin
      res = max;
    end else if (val[3:0] == 4'h0) begin
      res = {val[7:4] - 4'h1, 4'h9};
    end else begin
      res = {val[7:4], val[3:0] - 4'h1};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_field.sv
// rtl/bcd_field.sv - one 2-digit BCD register with its own wrap value
module bcd_field
  import bcd_clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] val,
  output logic       carry
);

  logic [8:0] inc_res;

  assign inc_res = bcd2_inc(val, MAX);
  // Carry is combinational so the parent can ripple through every field in one edge
  assign carry   = inc & inc_res[8];

  // Field register: clear beats increment, increment beats decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= BCD_ZERO;
    end else if (clr) begin
      val <= BCD_ZERO;
    end else if (inc) begin
      val <= inc_res[7:0];
    end else if (dec) begin
      val <= bcd2_dec(val, MAX);
    end
  end

endmodule

// File: rtl/bcd_clock_core.sv
// rtl/bcd_clock_core.sv - parametrised BCD timekeeping core with set mode and blink
module bcd_clock_core
  import bcd_clock_pkg::*;
#(
  parameter int                          NUM_FIELDS  = 3,
  parameter logic [8*NUM_FIELDS-1:0]     FIELD_MAX   = {8'h23, 8'h59, 8'h59},
  parameter int                          BLINK_TICKS = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tick,
  input  logic                          i_set,
  input  logic                          i_up,
  input  logic                          i_down,
  output logic [8*NUM_FIELDS-1:0]       o_bcd,
  output logic                          o_setting,
  output logic [$clog2(NUM_FIELDS)-1:0] o_field_sel,
  output logic                          o_blink,
  output logic                          o_wrap
);

  localparam int SW = $clog2(NUM_FIELDS);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            wrap_q, wrap_d;

  logic            is_run, is_set;
  logic            adj_up, adj_dn, exit_set;

  logic [NUM_FIELDS-1:0] f_inc, f_dec, f_clr, f_carry;

  assign is_run   = (state_q == ST_RUN);
  assign is_set   = (state_q == ST_SET);
  // i_set wins over adjustments; up and down together cancel
  assign adj_up   = is_set & ~i_set & i_up & ~i_down;
  assign adj_dn   = is_set & ~i_set & i_down & ~i_up;
  assign exit_set = is_set & i_set & (sel_q == '0);

  genvar k;
  generate
    for (k = 0; k < NUM_FIELDS; k++) begin : g_field
      if (k == 0) begin : g_lsb
        assign f_inc[k] = (is_run & i_tick) | (adj_up & (sel_q == SW'(k)));
        assign f_clr[k] = exit_set;
      end else begin : g_upper
        // Carries only ripple while counting time, never from set-mode edits
        assign f_inc[k] = (is_run & f_carry[k-1]) | (adj_up & (sel_q == SW'(k)));
        assign f_clr[k] = 1'b0;
      end
      assign f_dec[k] = adj_dn & (sel_q == SW'(k));

      bcd_field #(
        .MAX (FIELD_MAX[8*k +: 8])
      ) u_field (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (f_inc[k]),
        .dec   (f_dec[k]),
        .clr   (f_clr[k]),
        .val   (o_bcd[8*k +: 8]),
        .carry (f_carry[k])
      );
    end
  endgenerate

  // Mode state register and selected field index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next mode: set walks from the top field down to field 0, then back to RUN
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_RUN: begin
        if (i_set) begin
          state_d = ST_SET;
          sel_d   = SW'(NUM_FIELDS - 1);
        end
      end
      ST_SET: begin
        if (i_set) begin
          if (sel_q == '0) begin
            state_d = ST_RUN;
            sel_d   = '0;
          end else begin
            sel_d = sel_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        sel_d   = '0;
      end
    endcase
  end

  // Next outputs: blink pacing from ticks in SET, wrap pulse from the top carry in RUN
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    wrap_d      = is_run & f_carry[NUM_FIELDS-1];
    if (!is_set || i_set) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (i_tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      wrap_q      <= wrap_d;
    end
  end

  assign o_setting   = is_set;
  assign o_field_sel = sel_q;
  assign o_blink     = blink_q;
  assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_clock_core.sv
// tb/tb_bcd_clock_core.sv - directed self-checking bench for bcd_clock_core
module tb_bcd_clock_core;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_tick = 1'b0;
  logic        i_set = 1'b0;
  logic        i_up = 1'b0;
  logic        i_down = 1'b0;

  logic [23:0] o_bcd, o_bcd_b;
  logic        o_setting, o_setting_b;
  logic [1:0]  o_field_sel, o_field_sel_b;
  logic        o_blink, o_blink_b;
  logic        o_wrap, o_wrap_b;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  bcd_clock_core dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_set       (i_set),
    .i_up        (i_up),
    .i_down      (i_down),
    .o_bcd       (o_bcd),
    .o_setting   (o_setting),
    .o_field_sel (o_field_sel),
    .o_blink     (o_blink),
    .o_wrap      (o_wrap)
  );

  bcd_clock_core #(
    .BLINK_TICKS (2)
  ) dut_b2 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_set       (i_set),
    .i_up        (i_up),
    .i_down      (i_down),
    .o_bcd       (o_bcd_b),
    .o_setting   (o_setting_b),
    .o_field_sel (o_field_sel_b),
    .o_blink     (o_blink_b),
    .o_wrap      (o_wrap_b)
  );

  // One clock with the given strobes; returns #1 after the edge with strobes low
  task automatic cyc(input logic r, input logic t, input logic s, input logic u, input logic d);
    @(negedge i_clk);
    i_rst = r; i_tick = t; i_set = s; i_up = u; i_down = d;
    @(posedge i_clk);
    #1;
    i_rst = 0; i_tick = 0; i_set = 0; i_up = 0; i_down = 0;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    total++; if (o_bcd !== 24'h000000) begin bad++; $display("FAIL reset_bcd got=%h exp=000000", o_bcd); end
    total++; if (o_setting !== 1'b0 || o_blink !== 1'b0 || o_wrap !== 1'b0 || o_field_sel !== 2'd0) begin
      bad++; $display("FAIL reset_flags got set=%b blink=%b wrap=%b sel=%0d exp=0/0/0/0", o_setting, o_blink, o_wrap, o_field_sel);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h000010) begin bad++; $display("FAIL ten_ticks got=%h exp=000010", o_bcd); end
    total++; if (o_setting !== 1'b0 || o_blink !== 1'b0 || o_wrap !== 1'b0) begin
      bad++; $display("FAIL ten_ticks_flags got set=%b blink=%b wrap=%b exp=0/0/0", o_setting, o_blink, o_wrap);
    end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    total++; if (o_bcd !== 24'h230010) begin bad++; $display("FAIL hours_down got=%h exp=230010", o_bcd); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    total++; if (o_bcd !== 24'h235910) begin bad++; $display("FAIL minutes_down got=%h exp=235910", o_bcd); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    total++; if (o_bcd !== 24'h235900 || o_setting !== 1'b0) begin
      bad++; $display("FAIL preload_exit got=%h set=%b exp=235900 set=0", o_bcd, o_setting);
    end
    for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h235958) begin bad++; $display("FAIL tick58 got=%h exp=235958", o_bcd); end
    cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h235959 || o_wrap !== 1'b0) begin
      bad++; $display("FAIL tick59 got=%h wrap=%b exp=235959 wrap=0", o_bcd, o_wrap);
    end
    cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h000000 || o_wrap !== 1'b1) begin
      bad++; $display("FAIL day_wrap got=%h wrap=%b exp=000000 wrap=1", o_bcd, o_wrap);
    end
    cyc(0, 0, 0, 0, 0);
    total++; if (o_wrap !== 1'b0 || o_bcd !== 24'h000000) begin
      bad++; $display("FAIL wrap_pulse_end got=%h wrap=%b exp=000000 wrap=0", o_bcd, o_wrap);
    end
  endtask

  task automatic test_set_hours;
    cyc(0, 0, 1, 0, 0);
    total++; if (o_setting !== 1'b1 || o_field_sel !== 2'd2) begin
      bad++; $display("FAIL enter_set got set=%b sel=%0d exp=1/2", o_setting, o_field_sel);
    end
    cyc(0, 0, 0, 0, 1);
    total++; if (o_bcd !== 24'h230000) begin bad++; $display("FAIL hours_00_down got=%h exp=230000", o_bcd); end
    cyc(0, 0, 0, 1, 0);
    total++; if (o_bcd !== 24'h000000) begin bad++; $display("FAIL hours_23_up_nocarry got=%h exp=000000", o_bcd); end
    cyc(0, 0, 0, 0, 1);
    total++; if (o_bcd !== 24'h230000) begin bad++; $display("FAIL hours_down_again got=%h exp=230000", o_bcd); end
    cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h230000) begin bad++; $display("FAIL set_tick_no_count got=%h exp=230000", o_bcd); end
  endtask

  task automatic test_set_minutes;
    cyc(0, 0, 1, 0, 0);
    total++; if (o_field_sel !== 2'd1 || o_blink !== 1'b0) begin
      bad++; $display("FAIL sel_minutes got sel=%0d blink=%b exp=1/0", o_field_sel, o_blink);
    end
    cyc(0, 0, 0, 0, 1);
    total++; if (o_bcd !== 24'h235900) begin bad++; $display("FAIL minutes_00_down got=%h exp=235900", o_bcd); end
    cyc(0, 0, 0, 1, 1);
    total++; if (o_bcd !== 24'h235900) begin bad++; $display("FAIL up_down_cancel got=%h exp=235900", o_bcd); end
    cyc(0, 0, 1, 1, 0);
    total++; if (o_bcd !== 24'h235900 || o_field_sel !== 2'd0) begin
      bad++; $display("FAIL set_beats_up got=%h sel=%0d exp=235900 sel=0", o_bcd, o_field_sel);
    end
  endtask

  task automatic test_blink;
    logic exp_b1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_b2 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      total++; if (o_blink !== exp_b1[i] || o_blink_b !== exp_b2[i]) begin
        bad++; $display("FAIL blink_tick%0d got=%b/%b exp=%b/%b", i, o_blink, o_blink_b, exp_b1[i], exp_b2[i]);
      end
    end
    total++; if (o_bcd !== 24'h235900 || o_bcd_b !== 24'h235900) begin
      bad++; $display("FAIL blink_no_count got=%h/%h exp=235900", o_bcd, o_bcd_b);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd_b !== 24'h235901 || o_blink_b !== 1'b0 || o_blink !== 1'b1) begin
      bad++; $display("FAIL seconds_up got=%h blink=%b/%b exp=235901 1/0", o_bcd_b, o_blink, o_blink_b);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    total++; if (o_bcd_b !== 24'h235900 || o_setting_b !== 1'b0 || o_blink_b !== 1'b0 || o_blink !== 1'b0) begin
      bad++; $display("FAIL exit_set got=%h set=%b blink=%b/%b exp=235900 0 0/0", o_bcd_b, o_setting_b, o_blink, o_blink_b);
    end
    cyc(0, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h235901 || o_bcd_b !== 24'h235901) begin
      bad++; $display("FAIL run_resumes got=%h/%h exp=235901", o_bcd, o_bcd_b);
    end
  endtask

  task automatic test_reset_mid_set;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    total++; if (o_field_sel !== 2'd1 || o_setting !== 1'b1) begin
      bad++; $display("FAIL pre_reset_sel got sel=%0d set=%b exp=1/1", o_field_sel, o_setting);
    end
    cyc(1, 0, 0, 1, 0);
    total++; if (o_bcd !== 24'h000000 || o_setting !== 1'b0 || o_field_sel !== 2'd0 || o_blink !== 1'b0) begin
      bad++; $display("FAIL reset_mid_set got=%h set=%b sel=%0d blink=%b exp=000000 0 0 0", o_bcd, o_setting, o_field_sel, o_blink);
    end
    cyc(1, 1, 0, 0, 0);
    total++; if (o_bcd !== 24'h000000) begin bad++; $display("FAIL reset_beats_tick got=%h exp=000000", o_bcd); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_set_hours;
    test_set_minutes;
    test_blink;
    test_reset_mid_set;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
